// File: rtl/load_store_unit.sv
// Load/store back end: two store stations snoop the result buses and commit to memory,
// two load stations issue one per cycle once no busy store holds the same address.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] instbus1,
  input  logic [39:0] instbus2,
  input  logic [39:0] addbus,
  input  logic [39:0] multbus,
  input  logic [39:0] loadbus,
  input  logic [31:0] reg0,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [31:0] reg3,
  input  logic [31:0] data_in,
  output logic [15:0] ld_addr,
  output logic [39:0] loadout,
  output logic [31:0] data_out,
  output logic [15:0] st_addr,
  output logic [7:0]  storesig,
  output logic [7:0]  ST0_t,
  output logic [7:0]  ST1_t,
  output logic [15:0] ST0_addr,
  output logic [15:0] ST1_addr
);

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] TAG_R0   = 8'h01;
  localparam logic [7:0] TAG_R1   = 8'h02;
  localparam logic [7:0] TAG_R2   = 8'h03;
  localparam logic [7:0] TAG_R3   = 8'h04;
  localparam logic [7:0] TAG_LD0  = 8'h31;
  localparam logic [7:0] TAG_LD1  = 8'h32;
  localparam logic [7:0] TAG_ST0  = 8'h41;
  localparam logic [7:0] TAG_ST1  = 8'h42;

  logic [1:0]  st_busy_q, st_busy_d, st_ready_q, st_ready_d;
  logic [7:0]  st_src_q [2];
  logic [7:0]  st_src_d [2];
  logic [15:0] st_adr_q [2];
  logic [15:0] st_adr_d [2];
  logic [31:0] st_data_q [2];
  logic [31:0] st_data_d [2];
  logic [1:0]  ld_busy_q, ld_busy_d;
  logic [15:0] ld_adr_q [2];
  logic [15:0] ld_adr_d [2];
  logic [39:0] loadout_q, loadout_d;
  logic [31:0] data_out_q, data_out_d;
  logic [15:0] st_addr_q, st_addr_d;
  logic [7:0]  storesig_q, storesig_d;

  logic [1:0]  st_disp, ld_disp, ld_blocked;
  logic [39:0] st_inst [2];
  logic [39:0] ld_inst [2];
  logic [32:0] st_res [2];

  // Tag 0 never matches; an X/Z tag makes the compare unknown, which the caller treats as a miss.
  function automatic logic bus_hit(input logic [39:0] b, input logic [7:0] src);
    return (b[39:32] != 8'h00) && (b[39:32] == src);
  endfunction

  function automatic logic [32:0] resolve_src(input logic [7:0] src,
      input logic [39:0] ab, input logic [39:0] mb, input logic [39:0] lb,
      input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
    logic [32:0] res;
    res = '0;
    if (src == TAG_R0)       res = {1'b1, r0};
    else if (src == TAG_R1)  res = {1'b1, r1};
    else if (src == TAG_R2)  res = {1'b1, r2};
    else if (src == TAG_R3)  res = {1'b1, r3};
    else if (bus_hit(ab, src)) res = {1'b1, ab[31:0]};
    else if (bus_hit(mb, src)) res = {1'b1, mb[31:0]};
    else if (bus_hit(lb, src)) res = {1'b1, lb[31:0]};
    return res;
  endfunction

  // The older slot wins when both buses target the same free station.
  always_comb begin
    st_disp = '0;
    ld_disp = '0;
    for (int i = 0; i < 2; i++) begin
      st_inst[i] = instbus1;
      ld_inst[i] = instbus1;
      if (instbus1[31:24] == OP_STORE && instbus1[7:0] == (i == 0 ? TAG_ST0 : TAG_ST1)) begin
        st_disp[i] = 1'b1;
      end else if (instbus2[31:24] == OP_STORE && instbus2[7:0] == (i == 0 ? TAG_ST0 : TAG_ST1)) begin
        st_disp[i] = 1'b1;
        st_inst[i] = instbus2;
      end
      if (instbus1[31:24] == OP_LOAD && instbus1[39:32] == (i == 0 ? TAG_LD0 : TAG_LD1)) begin
        ld_disp[i] = 1'b1;
      end else if (instbus2[31:24] == OP_LOAD && instbus2[39:32] == (i == 0 ? TAG_LD0 : TAG_LD1)) begin
        ld_disp[i] = 1'b1;
        ld_inst[i] = instbus2;
      end
      st_res[i] = resolve_src(st_busy_q[i] ? st_src_q[i] : st_inst[i][39:32],
                              addbus, multbus, loadbus, reg0, reg1, reg2, reg3);
      ld_blocked[i] = (st_busy_q[0] && st_adr_q[0] == ld_adr_q[i]) ||
                      (st_busy_q[1] && st_adr_q[1] == ld_adr_q[i]);
    end
  end

  always_comb begin
    st_busy_d  = st_busy_q;
    st_ready_d = st_ready_q;
    st_src_d   = st_src_q;
    st_adr_d   = st_adr_q;
    st_data_d  = st_data_q;
    ld_busy_d  = ld_busy_q;
    ld_adr_d   = ld_adr_q;
    loadout_d  = '0;
    storesig_d = '0;
    data_out_d = data_out_q;
    st_addr_d  = st_addr_q;
    ld_addr    = '0;

    if (st_ready_q[0]) begin
      storesig_d = TAG_ST0;
      data_out_d = st_data_q[0];
      st_addr_d  = st_adr_q[0];
      st_busy_d[0]  = 1'b0;
      st_ready_d[0] = 1'b0;
    end else if (st_ready_q[1]) begin
      storesig_d = TAG_ST1;
      data_out_d = st_data_q[1];
      st_addr_d  = st_adr_q[1];
      st_busy_d[1]  = 1'b0;
      st_ready_d[1] = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      if (st_busy_q[i] && !st_ready_q[i]) begin
        if (st_res[i][32]) begin
          st_ready_d[i] = 1'b1;
          st_data_d[i]  = st_res[i][31:0];
        end
      end else if (!st_busy_q[i] && st_disp[i]) begin
        st_busy_d[i]  = 1'b1;
        st_src_d[i]   = st_inst[i][39:32];
        st_adr_d[i]   = st_inst[i][23:8];
        st_ready_d[i] = st_res[i][32];
        st_data_d[i]  = st_res[i][31:0];
      end
    end

    if (ld_busy_q[0] && !ld_blocked[0]) begin
      ld_addr      = ld_adr_q[0];
      loadout_d    = {TAG_LD0, data_in};
      ld_busy_d[0] = 1'b0;
    end else if (ld_busy_q[1] && !ld_blocked[1]) begin
      ld_addr      = ld_adr_q[1];
      loadout_d    = {TAG_LD1, data_in};
      ld_busy_d[1] = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      if (!ld_busy_q[i] && ld_disp[i]) begin
        ld_busy_d[i] = 1'b1;
        ld_adr_d[i]  = ld_inst[i][23:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_busy_q  <= '0;
      st_ready_q <= '0;
      ld_busy_q  <= '0;
      loadout_q  <= '0;
      data_out_q <= '0;
      st_addr_q  <= '0;
      storesig_q <= '0;
      for (int i = 0; i < 2; i++) begin
        st_src_q[i]  <= '0;
        st_adr_q[i]  <= '0;
        st_data_q[i] <= '0;
        ld_adr_q[i]  <= '0;
      end
    end else begin
      st_busy_q  <= st_busy_d;
      st_ready_q <= st_ready_d;
      ld_busy_q  <= ld_busy_d;
      loadout_q  <= loadout_d;
      data_out_q <= data_out_d;
      st_addr_q  <= st_addr_d;
      storesig_q <= storesig_d;
      for (int i = 0; i < 2; i++) begin
        st_src_q[i]  <= st_src_d[i];
        st_adr_q[i]  <= st_adr_d[i];
        st_data_q[i] <= st_data_d[i];
        ld_adr_q[i]  <= ld_adr_d[i];
      end
    end
  end

  assign loadout  = loadout_q;
  assign data_out = data_out_q;
  assign st_addr  = st_addr_q;
  assign storesig = storesig_q;
  assign ST0_t    = st_busy_q[0] ? st_src_q[0] : 8'h00;
  assign ST1_t    = st_busy_q[1] ? st_src_q[1] : 8'h00;
  assign ST0_addr = st_busy_q[0] ? st_adr_q[0] : 16'h0000;
  assign ST1_addr = st_busy_q[1] ? st_adr_q[1] : 16'h0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; loadbus is looped back from loadout as at the core top.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] instbus1, instbus2, addbus, multbus;
  logic [31:0] reg0, reg1, reg2, reg3, data_in;
  logic [15:0] ld_addr, st_addr, ST0_addr, ST1_addr;
  logic [39:0] loadout;
  logic [31:0] data_out;
  logic [7:0]  storesig, ST0_t, ST1_t;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .instbus1(instbus1), .instbus2(instbus2),
    .addbus(addbus), .multbus(multbus), .loadbus(loadout),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .data_in(data_in),
    .ld_addr(ld_addr), .loadout(loadout), .data_out(data_out), .st_addr(st_addr),
    .storesig(storesig), .ST0_t(ST0_t), .ST1_t(ST1_t), .ST0_addr(ST0_addr), .ST1_addr(ST1_addr)
  );

  function automatic logic [39:0] mk(input logic [7:0] f1, input logic [7:0] op,
                                     input logic [15:0] a, input logic [7:0] f2);
    return {f1, op, a, f2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    instbus1 = '0; instbus2 = '0; addbus = '0; multbus = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instbus1 = mk(8'h04, 8'h02, 16'h5555, 8'h41);
    instbus2 = mk(8'h31, 8'h01, 16'h1234, 8'h01);
    addbus = {8'h11, 32'h1};
    reg3 = 32'hdeadbeef;
    step(); step();
    checks++; if (storesig !== 8'h00) begin failures++; $display("FAIL rst_storesig got=%h exp=00", storesig); end
    checks++; if (loadout !== 40'h0) begin failures++; $display("FAIL rst_loadout got=%h exp=0", loadout); end
    checks++; if (data_out !== 32'h0 || st_addr !== 16'h0) begin failures++; $display("FAIL rst_dout got=%h/%h exp=0/0", data_out, st_addr); end
    checks++; if (ST0_t !== 8'h0 || ST0_addr !== 16'h0 || ST1_t !== 8'h0 || ST1_addr !== 16'h0) begin failures++; $display("FAIL rst_st got=%h %h %h %h exp=0", ST0_t, ST0_addr, ST1_t, ST1_addr); end
    checks++; if (ld_addr !== 16'h0) begin failures++; $display("FAIL rst_ldaddr got=%h exp=0000", ld_addr); end
    clear_bus();
    rst_n = 1'b1;
    step();
    checks++; if (ST0_t !== 8'h0 || loadout !== 40'h0 || storesig !== 8'h0) begin failures++; $display("FAIL rst_nocapture got=%h %h %h exp=0", ST0_t, loadout, storesig); end
  endtask

  task automatic test_conflict();
    instbus1 = mk(8'h31, 8'h01, 16'h2323, 8'h01);
    instbus2 = mk(8'h12, 8'h02, 16'h2323, 8'h41);
    data_in = 32'hcafe0001;
    step(); clear_bus();
    checks++; if (ST0_t !== 8'h12 || ST0_addr !== 16'h2323) begin failures++; $display("FAIL cf_disp got=%h/%h exp=12/2323", ST0_t, ST0_addr); end
    checks++; if (ld_addr !== 16'h0) begin failures++; $display("FAIL cf_blocked0 got=%h exp=0000", ld_addr); end
    step();
    checks++; if (loadout !== 40'h0 || storesig !== 8'h0) begin failures++; $display("FAIL cf_wait got=%h/%h exp=0/00", loadout, storesig); end
    addbus = {8'h12, 32'h12345678};
    step(); addbus = '0;
    checks++; if (storesig !== 8'h0 || ld_addr !== 16'h0) begin failures++; $display("FAIL cf_captured got=%h/%h exp=00/0000", storesig, ld_addr); end
    step();
    checks++; if (storesig !== 8'h41 || data_out !== 32'h12345678 || st_addr !== 16'h2323) begin failures++; $display("FAIL cf_commit got=%h %h %h exp=41 12345678 2323", storesig, data_out, st_addr); end
    checks++; if (ST0_t !== 8'h0 || ld_addr !== 16'h2323 || loadout !== 40'h0) begin failures++; $display("FAIL cf_unblock got=%h %h %h exp=00 2323 0", ST0_t, ld_addr, loadout); end
    step();
    checks++; if (loadout !== {8'h31, 32'hcafe0001} || storesig !== 8'h0) begin failures++; $display("FAIL cf_load got=%h/%h exp=31cafe0001/00", loadout, storesig); end
    step();
    checks++; if (loadout !== 40'h0) begin failures++; $display("FAIL cf_pulse got=%h exp=0", loadout); end
  endtask

  task automatic test_mult();
    instbus1 = mk(8'h21, 8'h02, 16'h1414, 8'h42);
    instbus2 = mk(8'h32, 8'h01, 16'h1414, 8'h03);
    data_in = 32'h0000beef;
    step(); clear_bus();
    checks++; if (ST1_t !== 8'h21 || ST1_addr !== 16'h1414) begin failures++; $display("FAIL mu_disp got=%h/%h exp=21/1414", ST1_t, ST1_addr); end
    multbus = {8'h21, 32'h00004567};
    step(); multbus = '0;
    checks++; if (ST1_t !== 8'h21) begin failures++; $display("FAIL mu_srcheld got=%h exp=21", ST1_t); end
    step();
    checks++; if (storesig !== 8'h42 || data_out !== 32'h00004567 || st_addr !== 16'h1414) begin failures++; $display("FAIL mu_commit got=%h %h %h exp=42 00004567 1414", storesig, data_out, st_addr); end
    step();
    checks++; if (loadout !== {8'h32, 32'h0000beef}) begin failures++; $display("FAIL mu_load got=%h exp=320000beef", loadout); end
  endtask

  task automatic test_noconflict();
    instbus1 = mk(8'h31, 8'h01, 16'habcd, 8'h02);
    data_in = 32'h0098cdcd;
    step(); clear_bus();
    checks++; if (ld_addr !== 16'habcd || loadout !== 40'h0) begin failures++; $display("FAIL nc_issue got=%h/%h exp=abcd/0", ld_addr, loadout); end
    step();
    checks++; if (loadout !== {8'h31, 32'h0098cdcd}) begin failures++; $display("FAIL nc_load got=%h exp=310098cdcd", loadout); end
  endtask

  task automatic test_back_to_back();
    reg3 = 32'hdeadbeef;
    reg1 = 32'h11112222;
    instbus1 = mk(8'h04, 8'h02, 16'h5555, 8'h41);
    instbus2 = mk(8'h02, 8'h02, 16'h6666, 8'h42);
    step(); clear_bus();
    checks++; if (ST0_t !== 8'h04 || ST1_t !== 8'h02 || storesig !== 8'h0) begin failures++; $display("FAIL bb_disp got=%h %h %h exp=04 02 00", ST0_t, ST1_t, storesig); end
    step();
    checks++; if (storesig !== 8'h41 || data_out !== 32'hdeadbeef || st_addr !== 16'h5555 || ST1_t !== 8'h02) begin failures++; $display("FAIL bb_st0 got=%h %h %h %h exp=41 deadbeef 5555 02", storesig, data_out, st_addr, ST1_t); end
    step();
    checks++; if (storesig !== 8'h42 || data_out !== 32'h11112222 || st_addr !== 16'h6666) begin failures++; $display("FAIL bb_st1 got=%h %h %h exp=42 11112222 6666", storesig, data_out, st_addr); end
    step();
    checks++; if (storesig !== 8'h0 || data_out !== 32'h11112222 || st_addr !== 16'h6666) begin failures++; $display("FAIL bb_hold got=%h %h %h exp=00 11112222 6666", storesig, data_out, st_addr); end
  endtask

  task automatic test_busy_ignore();
    instbus1 = mk(8'h11, 8'h02, 16'h3478, 8'h41);
    instbus2 = mk(8'h31, 8'h01, 16'h3478, 8'h01);
    data_in = 32'h55aa55aa;
    reg0 = 32'h0badf00d;
    step();
    instbus1 = mk(8'h01, 8'h02, 16'h9999, 8'h41);
    instbus2 = mk(8'h31, 8'h01, 16'h1111, 8'h01);
    step(); clear_bus();
    checks++; if (ST0_t !== 8'h11 || ST0_addr !== 16'h3478) begin failures++; $display("FAIL bi_st0 got=%h/%h exp=11/3478", ST0_t, ST0_addr); end
    checks++; if (ld_addr !== 16'h0 || storesig !== 8'h0 || loadout !== 40'h0) begin failures++; $display("FAIL bi_ld got=%h %h %h exp=0000 00 0", ld_addr, storesig, loadout); end
    addbus = {8'h11, 32'h00870012};
    step(); addbus = '0;
    step();
    checks++; if (storesig !== 8'h41 || data_out !== 32'h00870012 || st_addr !== 16'h3478) begin failures++; $display("FAIL bi_commit got=%h %h %h exp=41 00870012 3478", storesig, data_out, st_addr); end
    checks++; if (ld_addr !== 16'h3478) begin failures++; $display("FAIL bi_ldaddr got=%h exp=3478", ld_addr); end
    step();
    checks++; if (loadout !== {8'h31, 32'h55aa55aa}) begin failures++; $display("FAIL bi_load got=%h exp=3155aa55aa", loadout); end
  endtask

  task automatic test_bypass();
    instbus2 = mk(8'h11, 8'h02, 16'h7777, 8'h42);
    addbus = {8'h11, 32'h0000aaaa};
    step(); clear_bus();
    checks++; if (ST1_t !== 8'h11 || ST1_addr !== 16'h7777) begin failures++; $display("FAIL bp_disp got=%h/%h exp=11/7777", ST1_t, ST1_addr); end
    step();
    checks++; if (storesig !== 8'h42 || data_out !== 32'h0000aaaa || st_addr !== 16'h7777 || ST1_t !== 8'h0) begin failures++; $display("FAIL bp_commit got=%h %h %h %h exp=42 0000aaaa 7777 00", storesig, data_out, st_addr, ST1_t); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_bus();
    reg0 = '0; reg1 = '0; reg2 = '0; reg3 = '0; data_in = '0;
    test_reset();
    test_conflict();
    test_mult();
    test_noconflict();
    test_back_to_back();
    test_busy_ignore();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access back end of the superscalar core's dispatch/completion stage.
- Holds two store stations (ST0, ST1) and two load stations (LD0, LD1), filled from two instruction buses.
- Stores capture operand data from the register file or by snooping result buses, then commit to memory.
- Loads wait until no pending store matches their address, then read memory and broadcast the result on a 40-bit result bus.

Parameters:
- OP_LOAD, 8'h01, load opcode
- OP_STORE, 8'h02, store opcode
- TAG_R0..TAG_R3, 8'h01..8'h04, register tags (operand taken from reg0..reg3)
- TAG_A1, TAG_A2, 8'h11, 8'h12, adder result tags
- TAG_M0, 8'h21, multiplier result tag
- TAG_LD0, TAG_LD1, 8'h31, 8'h32, load station tags
- TAG_ST0, TAG_ST1, 8'h41, 8'h42, store station tags
- Tag 8'h00 means "none/invalid".

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- instbus1  in  40  {f1[39:32], op[31:24], addr[23:8], f2[7:0]}; older slot
- instbus2  in  40  same format; younger slot
- addbus  in  40  {tag[39:32], data[31:0]} adder result broadcast
- multbus  in  40  multiplier result broadcast
- loadbus  in  40  load result broadcast (top level connects it to loadout)
- reg0..reg3  in  32 each  register file values
- data_in  in  32  memory read data for ld_addr
- ld_addr  out  16  memory read address (combinational)
- loadout  out  40  {LD tag, data} load result, registered
- data_out  out  32  store data being committed
- st_addr  out  16  store commit address
- storesig  out  8  tag of committing store station; 0 = no commit
- ST0_t, ST1_t  out  8 each  pending source tag of each store station; 0 = free
- ST0_addr, ST1_addr  out  16 each  address held by each store station; 0 = free

Behaviour:
- Reset (rst_n=0 at an edge): all stations free. loadout, data_out, st_addr, storesig, ST*_t and ST*_addr = 0. ld_addr = 0.
- Bus values whose tag is 0, X or Z never match any tag.
- Dispatch, per bus, both buses in the same cycle:
  - op==OP_STORE, f2==TAG_STx and station free: station becomes busy with addr and src=f1.
  - If f1 is a register tag, data is captured from the corresponding reg0..reg3 at that edge and the station is ready.
  - Otherwise the station is busy-waiting on src.
- Dispatch of loads: op==OP_LOAD, f1==TAG_LDx and station free: station becomes busy with addr; f2 (destination) is not used by this block.
- An instruction targeting a busy station, or any other opcode, is ignored. Each instruction is presented for exactly one cycle.
- Snoop: each cycle, every waiting store compares addbus, multbus and loadbus tags with src.
  - On a match, data[31:0] is captured at that edge and the station becomes ready.
  - This includes the dispatch cycle (same-edge bypass).
- Store commit: a store that was ready at the start of a cycle commits at that edge.
  - Outputs data_out, st_addr and storesig (TAG_STx) for one cycle; the station is freed.
  - If both stores are ready, ST0 commits first; ST1 commits the next cycle.
  - storesig returns to 0 in cycles with no commit; data_out and st_addr hold their last values.
- ST0_t/ST0_addr report src/addr while busy. ST1_t/ST1_addr likewise. src stays reported until commit even after data is captured.
- Load hazard: a busy load is blocked while any busy store station (state after the current edge's dispatch is excluded; current registered state) holds an equal address.
  - This policy is conservative: a younger store to the same address also blocks the load.
- Load issue: one load per cycle. Among unblocked busy loads, LD0 has priority.
  - ld_addr = that load's addr, combinationally.
  - At the edge, loadout <= {TAG_LDx, data_in} and the station is freed.
  - A load cannot issue in its dispatch cycle; minimum latency is 1 cycle after dispatch.
- loadout = 0 in cycles with no issue (1-cycle pulse).
- A store committing at edge N unblocks a dependent load, which issues at edge N+1.

Test Plan:
- Reset: hold rst_n=0 two cycles with active buses -> all outputs 0, no station captures.
- Same-cycle load/store conflict:
  - instbus1={LD0,LOAD,2323,R0}, instbus2={A2,STORE,2323,ST0}. ST0_t=A2, ST0_addr=2323.
  - Load blocked until addbus={A2,12345678}.
  - Next edge: storesig=ST0, data_out=12345678, st_addr=2323.
  - Following edge: loadout={LD0,data_in}.
- Multiplier-sourced store: {M0,STORE,1414,ST1} plus {LD1,LOAD,1414,R2}; multbus={M0,00004567} -> commit data_out=00004567 at 1414, then loadout={LD1,data_in}.
- Non-conflicting load: {LD0,LOAD,abcd,R1} with no matching store, data_in=0098cdcd -> loadout={LD0,0098cdcd} one cycle after dispatch.
- Register-sourced store: {R3,STORE,5555,ST0}, reg3=deadbeef -> commit next cycle, data_out=deadbeef; also both stations ready in the same cycle -> ST0 then ST1 on consecutive edges.
- Busy-target ignore: dispatch to busy ST0 and to busy LD0 -> no state change. A1 store waits until addbus={A1,00870012], then commits 00870012 at 3478.
